ami_mem_responder: RTL and testbench

- Single-port AMI memory responder: the target-side end of the AMIRequest/AMIResponse handshake that traffic generators and applications drive.
- Backs requests with an on-chip array of 512-bit lines.
- Returns read data after a fixed pipeline latency through a response queue.
- Exposes request statistics over the soft-register interface.
- Used as a memory stand-in for application bring-up and self-test, without DRAM.

---
 rtl/ami_mem_responder_pkg.sv | 12 +
 rtl/ami_types_pkg.sv | 37 +++
 rtl/ami_line_ram.sv | 24 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/ami_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_ami_mem_responder.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/ami_mem_responder_pkg.sv
// Constants local to the AMI memory responder: line width and the
// statistics soft-register map.
package ami_mem_responder_pkg;

    localparam int LINE_W = 512;

    localparam logic [31:0] SR_READS     = 32'd0;
    localparam logic [31:0] SR_WRITES    = 32'd1;
    localparam logic [31:0] SR_MISALIGN  = 32'd2;
    localparam logic [31:0] SR_STALL_CLR = 32'd3;

endpackage

// File: rtl/ami_types_pkg.sv
// Shared AMI / soft-register transport types used by applications,
// traffic generators and memory targets.
//   AMIRequest  : {valid, isWrite, addr[63:0], data[511:0], size}
//   AMIResponse : {valid, data[511:0], size}
//   SoftRegReq  : {valid, isWrite, addr[31:0], data[63:0]}
//   SoftRegResp : {valid, data[63:0]}
package ami_types_pkg;

    localparam int AMI_SIZE_W = 7;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [63:0]           addr;
        logic [511:0]          data;
        logic [AMI_SIZE_W-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                  valid;
        logic [511:0]          data;
        logic [AMI_SIZE_W-1:0] size;
    } AMIResponse;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

endpackage

// File: rtl/ami_line_ram.sv
// Simple dual-port line array, write-first, registered read, no reset.
//   clk           : clock
//   we/waddr/wdata: write port
//   re/raddr      : read port; rdata updates on the edge after re
module ami_line_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word-fall-through.
//   clk, reset_n  : clock, async active-low reset (pointers/count only)
//   enq, din      : push (caller guarantees !full)
//   deq, dout     : pop (caller guarantees !empty); dout is the head
//   empty, full   : status
//   count         : occupancy, 0..2^LOG_DEPTH
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enq,
    input  logic [WIDTH-1:0]     din,
    input  logic                 deq,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH-1:0] wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = count[LOG_DEPTH];

endmodule

// File: rtl/ami_mem_responder.sv
// AMI memory responder: target side of the AMIRequest/AMIResponse
// handshake, backed by an on-chip line array, with request statistics
// on the soft-register interface.
//   clk, rst_n      : clock, async active-low reset (released synchronously)
//   mem_req         : request in;  mem_req_grant : accepted this cycle
//   mem_resp        : read response (queue head); mem_resp_grant : consumed
//   softreg_req     : statistics read / clear;  softreg_resp : read data
module ami_mem_responder
    import ami_types_pkg::*;
    import ami_mem_responder_pkg::*;
#(
    parameter int LINE_LOG_DEPTH = 10,
    parameter int READ_LATENCY   = 2,
    parameter int RESP_LOG_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  AMIRequest  mem_req,
    output logic       mem_req_grant,
    output AMIResponse mem_resp,
    input  logic       mem_resp_grant,
    input  SoftRegReq  softreg_req,
    output SoftRegResp softreg_resp
);
    localparam int CW  = RESP_LOG_DEPTH + 1;
    localparam int DLY = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    logic [1:0] rst_sync;
    logic       rst_ready;

    // Everything except the response queue stays held until two edges
    // after rst_n rises, so the release is clean w.r.t. clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ready = rst_sync[1];

    logic [LINE_LOG_DEPTH-1:0] line_idx;
    logic [READ_LATENCY-1:0]   rd_vld;
    logic [CW-1:0]             q_count;
    logic [CW-1:0]             in_pipe;
    logic [CW-1:0]             credits;
    logic                      rd_go;
    logic                      wr_go;

    assign line_idx = mem_req.addr[6 +: LINE_LOG_DEPTH];

    // Every read in the pipeline already owns a queue slot, so the queue
    // can never overflow.
    always_comb begin
        in_pipe = '0;
        for (int i = 0; i < READ_LATENCY; i++) in_pipe = in_pipe + CW'(rd_vld[i]);
    end
    assign credits = CW'(1 << RESP_LOG_DEPTH) - q_count - in_pipe;

    assign mem_req_grant = rst_ready && mem_req.valid && (mem_req.isWrite || credits != '0);
    assign wr_go         = mem_req_grant && mem_req.isWrite;
    assign rd_go         = mem_req_grant && !mem_req.isWrite;

    logic [LINE_W-1:0] ram_rdata;

    ami_line_ram #(
        .ADDR_W (LINE_LOG_DEPTH),
        .DATA_W (LINE_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_go),
        .waddr (line_idx),
        .wdata (mem_req.data),
        .re    (rd_go),
        .raddr (line_idx),
        .rdata (ram_rdata)
    );

    logic [AMI_SIZE_W-1:0] rd_size [READ_LATENCY];
    logic [LINE_W-1:0]     rd_dly  [DLY];
    logic [LINE_W-1:0]     enq_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= '0;
        end else if (!rst_ready) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= rd_go;
            for (int i = 1; i < READ_LATENCY; i++) rd_vld[i] <= rd_vld[i-1];
        end
    end

    // RAM output is valid alongside rd_vld[0]; rd_dly[k] lines up with rd_vld[k+1].
    always_ff @(posedge clk) begin
        rd_size[0] <= mem_req.size;
        for (int i = 1; i < READ_LATENCY; i++) rd_size[i] <= rd_size[i-1];
        rd_dly[0] <= ram_rdata;
        for (int i = 1; i < DLY; i++) rd_dly[i] <= rd_dly[i-1];
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign enq_data = ram_rdata;
    end else begin : g_latn
        assign enq_data = rd_dly[READ_LATENCY-2];
    end

    logic                         q_empty;
    logic                         q_full;
    logic [LINE_W+AMI_SIZE_W-1:0] q_dout;

    sync_fifo #(
        .WIDTH     (LINE_W + AMI_SIZE_W),
        .LOG_DEPTH (RESP_LOG_DEPTH)
    ) u_resp_q (
        .clk     (clk),
        .reset_n (rst_n),
        .enq     (rd_vld[READ_LATENCY-1]),
        .din     ({enq_data, rd_size[READ_LATENCY-1]}),
        .deq     (mem_resp_grant && !q_empty),
        .dout    (q_dout),
        .empty   (q_empty),
        .full    (q_full),
        .count   (q_count)
    );

    assign mem_resp = {!q_empty, q_dout};

    logic [63:0] read_cnt;
    logic [63:0] write_cnt;
    logic [63:0] misaligned_cnt;
    logic [31:0] stall_cnt;
    logic        sr_clr;
    logic [63:0] sr_rdata;

    assign sr_clr = softreg_req.valid && softreg_req.isWrite && softreg_req.addr == SR_STALL_CLR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_cnt       <= '0;
            write_cnt      <= '0;
            misaligned_cnt <= '0;
            stall_cnt      <= '0;
        end else if (!rst_ready || sr_clr) begin
            read_cnt       <= '0;
            write_cnt      <= '0;
            misaligned_cnt <= '0;
            stall_cnt      <= '0;
        end else begin
            if (rd_go) read_cnt <= read_cnt + 64'd1;
            if (wr_go) write_cnt <= write_cnt + 64'd1;
            if (mem_req_grant && mem_req.addr[5:0] != 6'd0)
                misaligned_cnt <= misaligned_cnt + 64'd1;
            if (mem_req.valid && !mem_req_grant && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        sr_rdata = '0;
        case (softreg_req.addr)
            SR_READS:     sr_rdata = read_cnt;
            SR_WRITES:    sr_rdata = write_cnt;
            SR_MISALIGN:  sr_rdata = misaligned_cnt;
            SR_STALL_CLR: sr_rdata = {32'b0, stall_cnt};
            default:      sr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            softreg_resp <= '0;
        end else if (!rst_ready) begin
            softreg_resp <= '0;
        end else begin
            softreg_resp.valid <= softreg_req.valid && !softreg_req.isWrite;
            softreg_resp.data  <= sr_rdata;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_req.addr[63:6+LINE_LOG_DEPTH], softreg_req.data, q_full};

endmodule

// File: tb/tb_ami_mem_responder.sv
module tb_ami_mem_responder;
    import ami_types_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    AMIRequest  mem_req;
    logic       mem_req_grant;
    AMIResponse mem_resp;
    logic       mem_resp_grant;
    SoftRegReq  softreg_req;
    SoftRegResp softreg_resp;

    always #5 clk = ~clk;

    ami_mem_responder #(
        .LINE_LOG_DEPTH (10),
        .READ_LATENCY   (2),
        .RESP_LOG_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_req_grant  (mem_req_grant),
        .mem_resp       (mem_resp),
        .mem_resp_grant (mem_resp_grant),
        .softreg_req    (softreg_req),
        .softreg_resp   (softreg_resp)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [511:0] mdl [int];
    logic [518:0] exp_q [$];
    int           outstanding = 0;
    int           sync_cnt = 0;
    logic         last_grant;
    logic [63:0]  m_reads, m_writes, m_mis;
    logic [31:0]  m_stall;

    task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        sync_cnt = 0;
        m_reads = '0; m_writes = '0; m_mis = '0; m_stall = '0;
    endtask

    task automatic drive_req(input logic v, input logic w, input logic [63:0] a,
                             input logic [511:0] d, input logic [6:0] s);
        mem_req = '{valid: v, isWrite: w, addr: a, data: d, size: s};
    endtask

    // Inputs are driven at posedge+1; the model samples at posedge+3.
    task automatic tick();
        logic g_exp;
        int   ln;
        #2;
        ln = int'(mem_req.addr[15:6]);
        g_exp = mem_req.valid && sync_cnt == 2 && (mem_req.isWrite || outstanding < 16);
        last_grant = mem_req_grant;
        chk("grant", mem_req_grant, g_exp);
        if (g_exp) begin
            if (mem_req.isWrite) begin
                mdl[ln] = mem_req.data;
                m_writes++;
            end else begin
                exp_q.push_back({mdl.exists(ln) ? mdl[ln] : 512'd0, mem_req.size});
                m_reads++;
                outstanding++;
            end
            if (mem_req.addr[5:0] != 6'd0) m_mis++;
        end else if (mem_req.valid && sync_cnt == 2 && m_stall != 32'hFFFF_FFFF) begin
            m_stall++;
        end
        if (mem_resp.valid && mem_resp_grant) begin
            chk("resp_present", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                chk("resp_data_size", {mem_resp.data, mem_resp.size}, exp_q.pop_front());
                outstanding--;
            end
        end
        if (sync_cnt == 2 && softreg_req.valid && softreg_req.isWrite && softreg_req.addr == 32'd3) begin
            m_reads = '0; m_writes = '0; m_mis = '0; m_stall = '0;
        end
        if (!rst_n) sync_cnt = 0;
        else if (sync_cnt < 2) sync_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic sr_read(input logic [31:0] a, input logic [63:0] exp, input string tag);
        softreg_req = '{valid: 1'b1, isWrite: 1'b0, addr: a, data: 64'd0};
        tick();
        softreg_req.valid = 1'b0;
        chk({tag, "_vld"}, softreg_resp.valid, 1'b1);
        chk(tag, softreg_resp.data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] a5;
        logic [511:0] d;
        logic [63:0]  a;
        int           n_g;
        a5 = {64{8'hA5}};
        model_reset();
        mem_resp_grant = 1'b0;
        softreg_req = '0;
        drive_req(1'b1, 1'b1, 64'h0, 512'd0, 7'd64);

        // reset state, including synchronous release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", mem_req_grant, 1'b0);
        chk("rst_resp_vld", mem_resp.valid, 1'b0);
        chk("rst_sr_vld", softreg_resp.valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        tick();

        // write line 5 then read it; response 3 cycles after grant
        drive_req(1'b1, 1'b1, 64'h140, a5, 7'd64);
        tick();
        drive_req(1'b1, 1'b0, 64'h140, 512'd0, 7'd64);
        tick();
        chk("raw_grant", last_grant, 1'b1);
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        mem_resp_grant = 1'b1;
        chk("lat_n1", mem_resp.valid, 1'b0);
        tick();
        chk("lat_n2", mem_resp.valid, 1'b0);
        tick();
        chk("lat_n3", mem_resp.valid, 1'b1);
        chk("raw_data", mem_resp.data, a5);
        chk("raw_size", mem_resp.size, 7'd64);
        tick();
        sr_read(32'd1, 64'd1, "write_cnt1");
        sr_read(32'd0, 64'd1, "read_cnt1");

        // address aliasing and misalignment
        drive_req(1'b1, 1'b0, 64'h141, 512'd0, 7'd64);
        tick();
        drive_req(1'b1, 1'b0, 64'h10140, 512'd0, 7'd32);
        tick();
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        repeat (5) tick();
        chk("alias_drained", exp_q.size(), 0);
        sr_read(32'd2, 64'd1, "misaligned_cnt1");

        // preload lines 0..15
        for (int i = 0; i < 16; i++) begin
            drive_req(1'b1, 1'b1, 64'(i * 64), {16{32'h1000_0000 + 32'(i)}}, 7'd64);
            tick();
        end

        // credit exhaustion with consumer stalled
        mem_resp_grant = 1'b0;
        n_g = 0;
        for (int i = 0; i < 20; i++) begin
            drive_req(1'b1, 1'b0, 64'((i % 16) * 64), 512'd0, 7'd64);
            tick();
            n_g += int'(last_grant);
        end
        chk("burst_grants", n_g, 16);
        chk("burst_last_stalled", last_grant, 1'b0);
        sr_read(32'd3, 64'd4, "stall_cnt4");
        sr_read(32'd3, 64'd5, "stall_cnt5");
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        mem_resp_grant = 1'b1;
        repeat (20) tick();
        chk("burst_drained", exp_q.size(), 0);
        chk("burst_resp_idle", mem_resp.valid, 1'b0);
        drive_req(1'b1, 1'b0, 64'(3 * 64), 512'd0, 7'd64);
        tick();
        chk("grant_resumed", last_grant, 1'b1);
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        repeat (4) tick();

        // counter clear coinciding with a read grant
        drive_req(1'b1, 1'b0, 64'(7 * 64), 512'd0, 7'd64);
        softreg_req = '{valid: 1'b1, isWrite: 1'b1, addr: 32'd3, data: 64'd0};
        tick();
        chk("clr_read_grant", last_grant, 1'b1);
        softreg_req = '0;
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        sr_read(32'd0, 64'd0, "read_cnt_cleared");
        sr_read(32'd1, 64'd0, "write_cnt_cleared");
        repeat (4) tick();

        // soft-register response latency
        softreg_req = '{valid: 1'b1, isWrite: 1'b0, addr: 32'd1, data: 64'd0};
        chk("sr_lat0", softreg_resp.valid, 1'b0);
        tick();
        softreg_req.valid = 1'b0;
        chk("sr_lat1", softreg_resp.valid, 1'b1);
        chk("sr_lat1_data", softreg_resp.data, 64'd0);
        tick();
        chk("sr_lat2", softreg_resp.valid, 1'b0);
        sr_read(32'd9, 64'd0, "sr_unmapped");

        // random mix with consumer toggling every cycle
        for (int i = 0; i < 1000; i++) begin
            mem_resp_grant = i[0];
            a = {$urandom(), 16'($urandom()), 6'd0, 4'($urandom_range(0, 15)), 6'd0};
            if ($urandom_range(0, 3) == 0) a[5:0] = 6'($urandom_range(1, 63));
            for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
            case ($urandom_range(0, 3))
                0:       drive_req(1'b0, 1'b0, a, d, 7'd64);
                1:       drive_req(1'b1, 1'b1, a, d, 7'd64);
                default: drive_req(1'b1, 1'b0, a, d, 7'($urandom_range(1, 64)));
            endcase
            tick();
        end
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        mem_resp_grant = 1'b1;
        repeat (40) tick();
        chk("rand_drained", exp_q.size(), 0);
        sr_read(32'd0, m_reads, "rand_read_cnt");
        sr_read(32'd1, m_writes, "rand_write_cnt");
        sr_read(32'd2, m_mis, "rand_misaligned_cnt");
        sr_read(32'd3, {32'b0, m_stall}, "rand_stall_cnt");

        // async reset with reads in flight
        mem_resp_grant = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_req(1'b1, 1'b0, 64'(i * 64), 512'd0, 7'd64);
            tick();
        end
        drive_req(1'b1, 1'b0, 64'(4 * 64), 512'd0, 7'd64);
        chk("pre_rst_resp_vld", mem_resp.valid, 1'b1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_grant", mem_req_grant, 1'b0);
        chk("async_rst_resp_vld", mem_resp.valid, 1'b0);
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        tick();
        tick();
        rst_n = 1'b1;
        mem_resp_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_stale_resp", mem_resp.valid, 1'b0);
        end
        drive_req(1'b1, 1'b0, 64'h140, 512'd0, 7'd64);
        tick();
        chk("post_rst_grant", last_grant, 1'b1);
        drive_req(1'b0, 1'b0, 64'h0, 512'd0, 7'd64);
        repeat (4) tick();
        chk("post_rst_read_done", exp_q.size(), 0);
        sr_read(32'd0, 64'd1, "post_rst_read_cnt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
